uart_baud_gen: RTL and testbench



---
 rtl/uart_baud_gen_if.sv | 26 ++
 rtl/uart_baud_gen.sv | 110 +++++++++++
 tb/tb_uart_baud_gen.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_baud_gen_if.sv
// Bus between the register block / UART datapaths and the baud generator.
// master = consumer side (drives divisor, enable, resync; receives ticks).
// slave  = the baud generator itself.
interface uart_baud_gen_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              en;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              rx_resync;
    logic              os_tick;
    logic              tx_tick;
    logic              rx_sample;

    modport master (
        output en, div_int, div_frac, div_load, rx_resync,
        input  os_tick, tx_tick, rx_sample
    );

    modport slave (
        input  en, div_int, div_frac, div_load, rx_resync,
        output os_tick, tx_tick, rx_sample
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Fractional baud-rate generator: oversample tick with an int+frac divisor,
// TX bit tick every OSR oversample ticks, and a re-phasable RX mid-bit strobe.
module uart_baud_gen #(
    parameter int DIV_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int OSR      = 16,
    parameter int DEF_INT  = 27,
    parameter int DEF_FRAC = 0
) (
    input  logic            clk,
    input  logic            rst,
    uart_baud_gen_if.slave  bus
);
    localparam int OSR_W = $clog2(OSR);
    localparam int CW    = DIV_W + 1;

    typedef struct packed {
        logic [DIV_W-1:0]  ip;
        logic [FRAC_W-1:0] fp;
    } div_t;

    localparam div_t DEF_DIV = '{ip: DIV_W'(DEF_INT), fp: FRAC_W'(DEF_FRAC)};

    // Divisors below 2 would make the period degenerate; force them up to 2.
    function automatic logic [DIV_W-1:0] clamp(input logic [DIV_W-1:0] v);
        return (v < DIV_W'(2)) ? DIV_W'(2) : v;
    endfunction

    div_t              act;
    div_t              pend;
    div_t              load_val;
    logic              pend_vld;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     period;
    logic [FRAC_W-1:0] acc;
    logic              stretch;
    logic [OSR_W-1:0]  tx_ph;
    logic [OSR_W-1:0]  rx_ph;
    logic              os_tick;
    logic              xfer;

    assign load_val = '{ip: clamp(bus.div_int), fp: bus.div_frac};
    assign period   = {1'b0, act.ip} + CW'(stretch);

    // Ticks are gated by rst so nothing escapes during the reset cycle.
    assign os_tick  = bus.en & ~rst & (cnt == period - CW'(1));

    // Pending divisor moves to active at a period boundary, or at once while frozen.
    assign xfer     = pend_vld & (os_tick | ~bus.en);

    // Pending/active divisor pair; a load coinciding with a transfer goes straight through.
    always_ff @(posedge clk) begin
        if (rst) begin
            act      <= DEF_DIV;
            pend     <= DEF_DIV;
            pend_vld <= 1'b0;
        end else begin
            if (xfer)
                act <= bus.div_load ? load_val : pend;
            if (bus.div_load) begin
                pend     <= load_val;
                pend_vld <= ~xfer;
            end else if (xfer) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // Period counter: restarts on each oversample tick, holds while disabled.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (os_tick)
            cnt <= '0;
        else if (bus.en)
            cnt <= cnt + CW'(1);
    end

    // Fractional accumulator; its carry stretches the following period by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            stretch <= 1'b0;
        end else if (os_tick) begin
            {stretch, acc} <= {1'b0, acc} + {1'b0, act.fp};
        end
    end

    // TX phase counts oversample ticks; wraps naturally since OSR is a power of two.
    always_ff @(posedge clk) begin
        if (rst)
            tx_ph <= '0;
        else if (os_tick)
            tx_ph <= tx_ph + OSR_W'(1);
    end

    // RX phase: resync wins over counting, so a tick in the resync cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst)
            rx_ph <= '0;
        else if (bus.rx_resync)
            rx_ph <= '0;
        else if (os_tick)
            rx_ph <= rx_ph + OSR_W'(1);
    end

    assign bus.os_tick   = os_tick;
    assign bus.tx_tick   = os_tick & (tx_ph == OSR_W'(OSR - 1));
    assign bus.rx_sample = os_tick & (rx_ph == OSR_W'(OSR / 2 - 1)) & ~bus.rx_resync;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen (DEF_INT=4, OSR=16, FRAC_W=4).
// Cycle 0 is the first cycle after reset release with en=1.
module tb_uart_baud_gen;
    localparam int DIV_W    = 16;
    localparam int FRAC_W   = 4;
    localparam int OSR      = 16;
    localparam int DEF_INT  = 4;
    localparam int DEF_FRAC = 0;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_baud_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bif ();

    uart_baud_gen #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR),
        .DEF_INT(DEF_INT), .DEF_FRAC(DEF_FRAC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int os_q[$];
    int tx_q[$];
    int rx_q[$];

    // Sample outputs mid-cycle, then advance past the next rising edge.
    task automatic cyc();
        @(negedge clk);
        if (bif.os_tick === 1'b1)   os_q.push_back(cyc_n);
        if (bif.tx_tick === 1'b1)   tx_q.push_back(cyc_n);
        if (bif.rx_sample === 1'b1) rx_q.push_back(cyc_n);
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic clr();
        os_q.delete();
        tx_q.delete();
        rx_q.delete();
        cyc_n = 0;
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic do_reset();
        rst           = 1'b1;
        bif.en        = 1'b0;
        bif.div_load  = 1'b0;
        bif.div_int   = '0;
        bif.div_frac  = '0;
        bif.rx_resync = 1'b0;
        run(2);
        rst = 1'b0;
        clr();
    endtask

    task automatic test_reset();
        do_reset();
        rst    = 1'b1;
        bif.en = 1'b1;
        run(6);
        checks++;
        if (os_q.size() + tx_q.size() + rx_q.size() !== 0)
            begin errors++; $display("FAIL reset_quiet: got %0d ticks, expected 0", os_q.size() + tx_q.size() + rx_q.size()); end
        rst = 1'b0;
        clr();
        run(4);
        checks++;
        if (qget(os_q, 0) !== 3 || os_q.size() !== 1)
            begin errors++; $display("FAIL reset_first_tick: got %0d (n=%0d), expected 3 (n=1)", qget(os_q, 0), os_q.size()); end
    endtask

    task automatic test_integer();
        int n63;
        do_reset();
        bif.en = 1'b1;
        run(130);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (qget(os_q, i) !== 3 + 4 * i)
                begin errors++; $display("FAIL int_os[%0d]: got %0d, expected %0d", i, qget(os_q, i), 3 + 4 * i); end
        end
        checks++;
        if (tx_q.size() !== 2 || qget(tx_q, 0) !== 63 || qget(tx_q, 1) !== 127)
            begin errors++; $display("FAIL int_tx: got n=%0d %0d %0d, expected n=2 63 127", tx_q.size(), qget(tx_q, 0), qget(tx_q, 1)); end
        n63 = 0;
        foreach (os_q[i]) if (os_q[i] <= 63) n63++;
        checks++;
        if (n63 !== 16)
            begin errors++; $display("FAIL int_os_per_tx: got %0d, expected 16", n63); end
        checks++;
        if (rx_q.size() !== 2 || qget(rx_q, 0) !== 31 || qget(rx_q, 1) !== 95)
            begin errors++; $display("FAIL int_rx: got n=%0d %0d %0d, expected n=2 31 95", rx_q.size(), qget(rx_q, 0), qget(rx_q, 1)); end
    endtask

    task automatic test_frac();
        int per[$];
        int exp5[5] = '{4, 4, 5, 4, 5};
        int sum, fives;
        do_reset();
        bif.div_int  = 16'd4;
        bif.div_frac = 4'd8;
        bif.div_load = 1'b1;
        cyc();
        bif.div_load = 1'b0;
        cyc();
        checks++;
        if (os_q.size() !== 0)
            begin errors++; $display("FAIL frac_frozen: got %0d ticks, expected 0", os_q.size()); end
        clr();
        bif.en = 1'b1;
        run(160);
        checks++;
        if (os_q.size() < 34)
            begin errors++; $display("FAIL frac_count: got %0d ticks, expected >= 34", os_q.size()); end
        per.push_back(qget(os_q, 0) + 1);
        for (int k = 1; k < 34; k++) per.push_back(qget(os_q, k) - qget(os_q, k - 1));
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (per[k] !== exp5[k])
                begin errors++; $display("FAIL frac_period[%0d]: got %0d, expected %0d", k, per[k], exp5[k]); end
        end
        sum = 0;
        fives = 0;
        for (int k = 1; k <= 32; k++) begin
            sum += per[k];
            if (per[k] == 5) fives++;
        end
        checks++;
        if (sum !== 144 || fives !== 16)
            begin errors++; $display("FAIL frac_32_periods: got sum %0d fives %0d, expected 144 16", sum, fives); end
    endtask

    task automatic test_reload();
        do_reset();
        bif.en      = 1'b1;
        bif.div_int = 16'd6;
        for (int c = 0; c < 20; c++) begin
            bif.div_load = (c == 1);
            cyc();
        end
        checks++;
        if (qget(os_q, 0) !== 3 || qget(os_q, 1) !== 9 || qget(os_q, 2) !== 15)
            begin errors++; $display("FAIL reload_ticks: got %0d %0d %0d, expected 3 9 15", qget(os_q, 0), qget(os_q, 1), qget(os_q, 2)); end
        do_reset();
        bif.div_int  = 16'd1;
        bif.div_load = 1'b1;
        cyc();
        bif.div_load = 1'b0;
        cyc();
        clr();
        bif.en = 1'b1;
        run(8);
        checks++;
        if (os_q.size() !== 4 || qget(os_q, 0) !== 1 || qget(os_q, 3) !== 7)
            begin errors++; $display("FAIL reload_clamp: got n=%0d first %0d last %0d, expected n=4 1 7", os_q.size(), qget(os_q, 0), qget(os_q, 3)); end
    endtask

    task automatic test_rx_resync();
        do_reset();
        bif.en = 1'b1;
        for (int c = 0; c < 110; c++) begin
            bif.rx_resync = (c == 10);
            cyc();
        end
        bif.rx_resync = 1'b0;
        checks++;
        if (rx_q.size() !== 2 || qget(rx_q, 0) !== 39 || qget(rx_q, 1) !== 103)
            begin errors++; $display("FAIL rx_resync: got n=%0d %0d %0d, expected n=2 39 103", rx_q.size(), qget(rx_q, 0), qget(rx_q, 1)); end
        do_reset();
        bif.en = 1'b1;
        for (int c = 0; c < 70; c++) begin
            bif.rx_resync = (c == 31);
            cyc();
        end
        bif.rx_resync = 1'b0;
        checks++;
        if (rx_q.size() !== 1 || qget(rx_q, 0) !== 63)
            begin errors++; $display("FAIL rx_resync_on_tick: got n=%0d %0d, expected n=1 63", rx_q.size(), qget(rx_q, 0)); end
    endtask

    task automatic test_enable();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            bif.en = !(c >= 2 && c <= 6);
            cyc();
        end
        checks++;
        if (qget(os_q, 0) !== 8 || qget(os_q, 1) !== 12 || qget(os_q, 2) !== 16)
            begin errors++; $display("FAIL enable_gap: got %0d %0d %0d, expected 8 12 16", qget(os_q, 0), qget(os_q, 1), qget(os_q, 2)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bif.en      = 1'b1;
        bif.div_int = 16'd9;
        for (int c = 0; c < 4; c++) begin
            bif.div_load = (c == 1);
            rst          = (c == 3);
            cyc();
        end
        bif.div_load = 1'b0;
        rst          = 1'b0;
        checks++;
        if (os_q.size() !== 0)
            begin errors++; $display("FAIL reset_mid_gate: got %0d ticks, expected 0", os_q.size()); end
        clr();
        run(12);
        checks++;
        if (qget(os_q, 0) !== 3 || qget(os_q, 1) !== 7 || qget(os_q, 2) !== 11)
            begin errors++; $display("FAIL reset_mid_div: got %0d %0d %0d, expected 3 7 11", qget(os_q, 0), qget(os_q, 1), qget(os_q, 2)); end
    endtask

    initial begin
        rst           = 1'b1;
        bif.en        = 1'b0;
        bif.div_load  = 1'b0;
        bif.div_int   = '0;
        bif.div_frac  = '0;
        bif.rx_resync = 1'b0;
        test_reset();
        test_integer();
        test_frac();
        test_reload();
        test_rx_resync();
        test_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
